// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-master bus arbiter.
//   arb_state_e       - arbiter FSM state encoding
//   ARB_TIMEOUT_RDATA - read data returned to the owner when the watchdog aborts
//   ARB_CNT_W         - width of the watchdog BUSY-cycle counter
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam logic [31:0] ARB_TIMEOUT_RDATA = 32'hDEAD_BEEF;
    localparam int          ARB_CNT_W         = 16;

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: counts BUSY cycles of the current grant and flags when the
// count reaches TIMEOUT. Only built when MEM_ARB_TIMEOUT_EN is defined.
// Ports:
//   clk, reset - system clock, asynchronous active-high reset
//   start      - a grant is being issued this cycle (clears the count)
//   active     - arbiter is in BUSY this cycle (count advances)
//   fire       - BUSY and the count equals TIMEOUT
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic active,
    output logic fire
);

    logic [ARB_CNT_W-1:0] cnt_q;
    logic [ARB_CNT_W-1:0] cnt_d;

    // The count is 0 in the first BUSY cycle, so fire lands after TIMEOUT
    // full BUSY cycles have gone by without a slave response.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (active) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fire = active && (cnt_q == ARB_CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter between two native-interface masters
// (m0 = CPU core, m1 = loader/DMA) sharing one memory/peripheral bus.
// A grant is held for exactly one valid/ready transaction.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to abort a transaction after
// TIMEOUT BUSY cycles without s_ready (owner gets ready + 32'hDEAD_BEEF and
// timeout_err pulses). Without it BUSY waits indefinitely, timeout_err = 0.
// Ports:
//   clk, reset                       - clock, asynchronous active-high reset
//   mX_valid/addr/wdata/wstrb        - master requests (wstrb == 0 is a read)
//   mX_ready/rdata                   - completion back to each master
//   s_valid/addr/wdata/wstrb         - request to the bus, muxed from owner
//   s_ready/rdata                    - slave completion and read data
//   busy                             - registered: a grant is held
//   timeout_err                      - one-cycle pulse on watchdog abort
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                m0_valid,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_ready,
    output logic [DATA_W-1:0]   m0_rdata,

    input  logic                m1_valid,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_ready,
    output logic [DATA_W-1:0]   m1_rdata,

    output logic                s_valid,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_ready,
    input  logic [DATA_W-1:0]   s_rdata,

    output logic                busy,
    output logic                timeout_err
);

    arb_state_e  state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q,  last_d;
    logic        busy_q,  busy_d;

    logic              owner_valid;
    logic              ready_int;
    logic [DATA_W-1:0] rdata_int;

`ifdef MEM_ARB_TIMEOUT_EN
    logic wd_start;
    logic wd_fire;

    assign wd_start = (state_q == ARB_IDLE) && (m0_valid || m1_valid);

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .start  (wd_start),
        .active (state_q == ARB_BUSY),
        .fire   (wd_fire)
    );
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT);
`endif

    assign owner_valid = owner_q ? m1_valid : m0_valid;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        s_valid     = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        m0_ready    = 1'b0;
        m1_ready    = 1'b0;
        m0_rdata    = '0;
        m1_rdata    = '0;
        ready_int   = 1'b0;
        rdata_int   = '0;
        timeout_err = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (m0_valid || m1_valid) begin
                    // On a tie the master that did not complete last wins.
                    owner_d = (m0_valid && m1_valid) ? ~last_q : m1_valid;
                    state_d = ARB_BUSY;
                end
            end

            ARB_BUSY: begin
                s_valid   = 1'b1;
                s_addr    = owner_q ? m1_addr  : m0_addr;
                s_wdata   = owner_q ? m1_wdata : m0_wdata;
                s_wstrb   = owner_q ? m1_wstrb : m0_wstrb;
                rdata_int = s_rdata;

                if (!owner_valid) begin
                    // Owner abandoned its request: release without a
                    // ready and without moving the round-robin pointer.
                    state_d = ARB_IDLE;
                end else if (s_ready) begin
                    ready_int = 1'b1;
                    state_d   = ARB_IDLE;
                    last_d    = owner_q;
`ifdef MEM_ARB_TIMEOUT_EN
                end else if (wd_fire) begin
                    ready_int   = 1'b1;
                    rdata_int   = DATA_W'(ARB_TIMEOUT_RDATA);
                    timeout_err = 1'b1;
                    state_d     = ARB_IDLE;
                    last_d      = owner_q;
`endif
                end

                if (owner_q) begin
                    m1_ready = ready_int;
                    m1_rdata = rdata_int;
                end else begin
                    m0_ready = ready_int;
                    m0_rdata = rdata_int;
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        busy_d = (state_d == ARB_BUSY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a response scoreboard.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk;
    logic          reset;
    logic          m0_valid, m1_valid;
    logic [AW-1:0] m0_addr,  m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic [SW-1:0] m0_wstrb, m1_wstrb;
    logic          m0_ready, m1_ready;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          s_valid;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [SW-1:0] s_wstrb;
    logic          s_ready;
    logic [DW-1:0] s_rdata;
    logic          busy;
    logic          timeout_err;

    mem_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m0_valid    (m0_valid),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_wstrb    (m0_wstrb),
        .m0_ready    (m0_ready),
        .m0_rdata    (m0_rdata),
        .m1_valid    (m1_valid),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_wstrb    (m1_wstrb),
        .m1_ready    (m1_ready),
        .m1_rdata    (m1_rdata),
        .s_valid     (s_valid),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_ready     (s_ready),
        .s_rdata     (s_rdata),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        who;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];

    logic        slave_hang = 1'b0;
    int          slave_wait = 0;
    logic [31:0] slave_data = '0;
    int          wait_cnt   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget, output int waited);
        waited = 0;
        while (sb.size() != 0 && waited < budget) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("sb_drain", sb.size(), 0);
    endtask

    // Slave model: answers after slave_wait BUSY cycles unless hung.
    initial begin
        s_ready = 1'b0;
        s_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            s_rdata = slave_data;
            if (s_valid && !slave_hang) begin
                if (wait_cnt >= slave_wait) begin
                    s_ready  = 1'b1;
                    wait_cnt = 0;
                end else begin
                    s_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                s_ready  = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Response monitor: every ready must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (m0_ready || m1_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ready", {62'd0, m1_ready, m0_ready}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ready_onehot", m0_ready & m1_ready, 0);
                    chk("ready_who", m1_ready, e.who);
                    chk("ready_rdata", e.who ? m1_rdata : m0_rdata, e.rdata);
                    chk("nonowner_rdata", e.who ? m0_rdata : m1_rdata, 0);
                    chk("ready_timeout_err", timeout_err, e.err);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit observed=expired expected=finish");
        $fatal(1);
    end

    initial begin
        int w;
        reset    = 1'b1;
        m0_valid = 1'b0; m1_valid = 1'b0;
        m0_addr  = '0;   m1_addr  = '0;
        m0_wdata = '0;   m1_wdata = '0;
        m0_wstrb = '0;   m1_wstrb = '0;

        // Reset values
        @(negedge clk);
        chk("rst_s_valid", s_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_readys", {m1_ready, m0_ready}, 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_rdatas", {m1_rdata, m0_rdata}, 0);
        @(negedge clk);
        reset = 1'b0;

        // m0 read, two slave wait cycles
        cyc();
        m0_valid = 1'b1; m0_addr = 32'h0000_0010; m0_wstrb = '0;
        slave_wait = 2; slave_data = 32'h1234_5678;
        sb.push_back('{who: 1'b0, rdata: 32'h1234_5678, err: 1'b0});
        @(negedge clk);
        chk("t1_svalid_n", s_valid, 0);
        cyc(); @(negedge clk);
        chk("t1_svalid_n1", s_valid, 1);
        chk("t1_saddr", s_addr, 32'h0000_0010);
        chk("t1_m0ready_n1", m0_ready, 0);
        cyc(); @(negedge clk);
        chk("t1_m0ready_n2", m0_ready, 0);
        cyc(); @(negedge clk);
        chk("t1_m0ready_n3", m0_ready, 1);
        chk("t1_m0rdata_n3", m0_rdata, 32'h1234_5678);
        chk("t1_m1ready_n3", m1_ready, 0);
        cyc();
        m0_valid = 1'b0;
        drain(5, w);

        // Both masters valid from reset: alternate m0, m1, m0, m1
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        cyc();
        m0_valid = 1'b1; m0_addr = 32'h20;
        m1_valid = 1'b1; m1_addr = 32'h24; m1_wstrb = '0;
        slave_wait = 0; slave_data = 32'hCAFE_0001;
        for (int i = 0; i < 4; i++)
            sb.push_back('{who: 1'(i % 2), rdata: 32'hCAFE_0001, err: 1'b0});
        drain(40, w);
        chk("b2b_cycles", w, 8);
        cyc();
        m0_valid = 1'b0; m1_valid = 1'b0;

        // m1 write; m0 presents unrelated bus values but is not valid
        cyc();
        m1_valid = 1'b1; m1_addr = 32'h0000_0100; m1_wdata = 32'hAABB_CCDD; m1_wstrb = 4'b0011;
        m0_addr = 32'hFFFF_0000; m0_wdata = 32'h1111_1111; m0_wstrb = 4'hF;
        slave_wait = 1; slave_data = 32'h5A5A_0003;
        sb.push_back('{who: 1'b1, rdata: 32'h5A5A_0003, err: 1'b0});
        @(negedge clk);
        chk("t3_idle_m1rdata", m1_rdata, 0);
        cyc(); @(negedge clk);
        chk("t3_svalid", s_valid, 1);
        chk("t3_saddr", s_addr, 32'h0000_0100);
        chk("t3_swdata", s_wdata, 32'hAABB_CCDD);
        chk("t3_swstrb", s_wstrb, 4'b0011);
        chk("t3_m0ready", m0_ready, 0);
        chk("t3_m0rdata", m0_rdata, 0);
        chk("t3_m1ready_wait", m1_ready, 0);
        cyc(); @(negedge clk);
        chk("t3_saddr_done", s_addr, 32'h0000_0100);
        chk("t3_m0ready_done", m0_ready, 0);
        chk("t3_m0rdata_done", m0_rdata, 0);
        cyc();
        m1_valid = 1'b0;
        m0_wstrb = '0;
        drain(5, w);

        // m0 completes (last = m0), then reset mid-transaction
        cyc();
        m0_valid = 1'b1; m0_addr = 32'h30;
        slave_wait = 0; slave_data = 32'h0000_4444;
        sb.push_back('{who: 1'b0, rdata: 32'h0000_4444, err: 1'b0});
        cyc(); cyc();
        m0_valid = 1'b0;
        drain(5, w);
        cyc();
        m0_valid = 1'b1; m0_addr = 32'h34; slave_hang = 1'b1;
        cyc(); cyc();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_svalid", s_valid, 0);
        chk("rst_mid_m0ready", m0_ready, 0);
        m0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0; slave_hang = 1'b0;
        chk("rst_mid_busy", busy, 0);
        cyc();
        m0_valid = 1'b1; m1_valid = 1'b1;
        slave_wait = 0; slave_data = 32'h0000_7777;
        sb.push_back('{who: 1'b0, rdata: 32'h0000_7777, err: 1'b0});
        sb.push_back('{who: 1'b1, rdata: 32'h0000_7777, err: 1'b0});
        drain(10, w);
        cyc();
        m0_valid = 1'b0; m1_valid = 1'b0;

        // Owner (m0) drops valid while BUSY; slave responds that cycle
        cyc();
        m0_valid = 1'b1; m0_addr = 32'h40;
        slave_wait = 1; slave_data = 32'h0000_9999;
        cyc(); cyc();
        m0_valid = 1'b0;
        @(negedge clk);
        chk("drop_m0ready", m0_ready, 0);
        chk("drop_m1ready", m1_ready, 0);
        cyc(); @(negedge clk);
        chk("drop_idle_svalid", s_valid, 0);
        cyc();
        m0_valid = 1'b1; m1_valid = 1'b1;
        slave_wait = 0; slave_data = 32'h0000_AAAA;
        sb.push_back('{who: 1'b0, rdata: 32'h0000_AAAA, err: 1'b0});
        sb.push_back('{who: 1'b1, rdata: 32'h0000_AAAA, err: 1'b0});
        drain(10, w);
        cyc();
        m0_valid = 1'b0; m1_valid = 1'b0;

        // Slave never responds
        cyc();
        m0_valid = 1'b1; m0_addr = 32'h50; slave_hang = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
        sb.push_back('{who: 1'b0, rdata: 32'hDEAD_BEEF, err: 1'b1});
        repeat (4) cyc();
        @(negedge clk);
        chk("wd_n4_m0ready", m0_ready, 0);
        chk("wd_n4_err", timeout_err, 0);
        cyc(); @(negedge clk);
        chk("wd_n5_err", timeout_err, 1);
        chk("wd_n5_m0ready", m0_ready, 1);
        chk("wd_n5_m0rdata", m0_rdata, 32'hDEAD_BEEF);
        cyc();
        m0_valid = 1'b0;
        @(negedge clk);
        chk("wd_n6_svalid", s_valid, 0);
        chk("wd_n6_err", timeout_err, 0);
        drain(5, w);
`else
        repeat (30) cyc();
        @(negedge clk);
        chk("hang_busy", busy, 1);
        chk("hang_svalid", s_valid, 1);
        chk("hang_m0ready", m0_ready, 0);
        chk("hang_err", timeout_err, 0);
        m0_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`endif
        slave_hang = 1'b0;
        repeat (2) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter sharing the SoC's single native-interface memory/peripheral bus between the picorv32 core (master 0) and a secondary requester such as a program loader or DMA (master 1). It sits between the masters and the bus decoder in `top`. Grants are round-robin and locked for the duration of one valid/ready transaction. An optional watchdog releases the bus when a slave never responds.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; write strobe width is `DATA_W/8`
- `TIMEOUT`, 255, BUSY cycles without `s_ready` before the watchdog fires (only with the macro); legal range 1..65535

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `m0_valid` / `m1_valid`  in  1  master request; held until its ready is seen
- `m0_addr` / `m1_addr`  in  ADDR_W  request address
- `m0_wdata` / `m1_wdata`  in  DATA_W  write data
- `m0_wstrb` / `m1_wstrb`  in  DATA_W/8  byte strobes; all zero means read
- `m0_ready` / `m1_ready`  out  1  transaction complete for that master
- `m0_rdata` / `m1_rdata`  out  DATA_W  read data, valid while the matching ready is high
- `s_valid`  out  1  request to the bus
- `s_addr`, `s_wdata`, `s_wstrb`  out  ADDR_W / DATA_W / DATA_W/8  muxed from the owner
- `s_ready`  in  1  slave completion
- `s_rdata`  in  DATA_W  slave read data
- `busy`  out  1  a grant is held
- `timeout_err`  out  1  one-cycle pulse when the watchdog aborts

## Operation
- States are IDLE and BUSY. `owner` (1 bit) and `last` (1 bit) are registered.
- **IDLE**
  - No valid: stay in IDLE.
  - Exactly one valid: grant that master.
  - Both valid: grant the master that is not `last`.
  - On grant: `owner` is set to the winner at the clock edge, and the state goes to BUSY.
- **BUSY**
  - `s_valid` = 1.
  - `s_addr`, `s_wdata`, `s_wstrb` are combinationally muxed from `owner`.
  - The owner's ready and rdata are combinationally `s_ready` and `s_rdata`.
  - The non-owner's ready is 0 and its rdata is 0.
- **Completion:** when `s_ready` = 1 in BUSY, at that edge the state goes to IDLE and `last` takes the value of `owner`.
- **Owner drops valid while BUSY** (protocol violation): at that edge the state goes to IDLE, no ready is issued to either master, and `last` is unchanged.
- **Outside BUSY:** `s_valid`, `s_addr`, `s_wdata`, `s_wstrb`, both readys and both rdatas are 0.
- **Reset values:** state IDLE, `owner` = 0, `last` = 1 (so master 0 wins the first tie), `busy` = 0, `timeout_err` = 0, and every output listed above is 0.

## Timing
- Arbitration latency is one cycle: a request first high in cycle N gets `s_valid` high in cycle N+1.
- Zero-wait slave: `s_ready` in cycle N+1 gives the master its ready in cycle N+1, then IDLE in cycle N+2.
  - Back-to-back throughput is therefore one transaction per 2 cycles.
- `busy` is a registered copy of (state == BUSY).
- The ready path is combinational: `s_ready` to `mX_ready` has no register.
- Asserting `reset` mid-transaction drops `s_valid` immediately (asynchronously) and discards the transaction.
- A request that arrives in the same cycle as a completion is arbitrated in the following IDLE cycle, with `last` already updated.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to BUSY and increments every BUSY cycle.
  - When the count equals `TIMEOUT` and `s_ready` = 0, the arbiter drives:
    - owner ready = 1 and owner rdata = 32'hDEAD_BEEF for that cycle;
    - `timeout_err` = 1 for that cycle.
  - It then goes to IDLE with `last` = `owner`.
  - If `s_ready` arrives in the same cycle, `s_ready` wins and no error is flagged.
- Not defined:
  - No counter is built.
  - BUSY waits indefinitely.
  - `timeout_err` is tied to 0.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum `{ARB_IDLE, ARB_BUSY}`;
  - the constant `ARB_TIMEOUT_RDATA` = 32'hDEAD_BEEF;
  - the counter width constant (16).
- Sub-module `mem_arb_watchdog` contains the counter and the compare. It is instantiated only under `MEM_ARB_TIMEOUT_EN`.
- The arbitration logic, FSM and muxes live in `mem_arbiter`.

## Test plan
- Master 0 read of 0x0000_0010 alone, slave ready after 2 wait cycles with rdata 0x1234_5678:
  - `s_valid` rises in cycle N+1;
  - `m0_ready` is high in cycle N+3 with `m0_rdata` = 0x1234_5678;
  - `m1_ready` stays 0.
- Both masters valid from reset:
  - m0 is granted first, m1 next;
  - with both held continuously, grants alternate m0, m1, m0, m1.
- Master 1 write to 0x0000_0100, wstrb 4'b0011, wdata 0xAABB_CCDD:
  - `s_addr`, `s_wstrb` and `s_wdata` match exactly while `s_valid` is high;
  - m0 sees ready = 0 and rdata = 0.
- Reset asserted in the middle of a BUSY transaction:
  - `s_valid` goes to 0 the same cycle;
  - after release, `busy` = 0 and the next tie goes to m0.
- Owner drops valid in BUSY: the arbiter returns to IDLE with no ready pulse to either master, and `last` is unchanged.
- With `MEM_ARB_TIMEOUT_EN`, `TIMEOUT` = 4, slave never ready:
  - owner ready, rdata 0xDEAD_BEEF and `timeout_err` appear together for one cycle;
  - the arbiter then returns to IDLE.
  - Without the macro, the same stimulus keeps `busy` high indefinitely.
